// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a_in - b_in, LSB first.
// A two-state Mealy borrow machine (p_state) carries the borrow between
// bits. A start/done handshake frames each D_WIDTH-cycle operation.
module serial_subtractor #(
  parameter int D_WIDTH = 8,
  parameter int C_WIDTH = 4
) (
  input  logic               i_clk,
  input  logic               reset,
  input  logic               start,
  input  logic [D_WIDTH-1:0] a_in,
  input  logic [D_WIDTH-1:0] b_in,
  output logic               busy,
  output logic               done,
  output logic [D_WIDTH-1:0] diff,
  output logic               borrow_out,
  output logic               ovf_out,
  output logic               p_state,
  output logic [C_WIDTH-1:0] count_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Difference bit of a full subtractor.
  function automatic logic sub_bit(input logic a, input logic b, input logic s);
    return a ^ b ^ s;
  endfunction

  // Borrow produced by a full subtractor: next Mealy borrow state.
  function automatic logic sub_borrow(input logic a, input logic b, input logic s);
    return (~a & b) | (~(a ^ b) & s);
  endfunction

  localparam logic [C_WIDTH-1:0] LAST_CNT = C_WIDTH'(D_WIDTH - 1);

  state_t             state_q, state_d;
  logic [D_WIDTH-1:0] a_sr_q, a_sr_d;
  logic [D_WIDTH-1:0] b_sr_q, b_sr_d;
  logic [D_WIDTH-1:0] diff_q, diff_d;
  logic [C_WIDTH-1:0] count_q, count_d;
  logic               p_state_q, p_state_d;
  logic               borrow_q, borrow_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic bit_a_s, bit_b_s, bit_d_s, next_s_s;

  assign bit_a_s  = a_sr_q[0];
  assign bit_b_s  = b_sr_q[0];
  assign bit_d_s  = sub_bit(bit_a_s, bit_b_s, p_state_q);
  assign next_s_s = sub_borrow(bit_a_s, bit_b_s, p_state_q);

  // Control FSM next state, datapath updates and registered-output values.
  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    diff_d    = diff_q;
    count_d   = count_q;
    p_state_d = p_state_q;
    borrow_d  = borrow_q;
    ovf_d     = ovf_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d    = a_in;
          b_sr_d    = b_in;
          diff_d    = {D_WIDTH{1'b0}};
          p_state_d = 1'b0;
          count_d   = {C_WIDTH{1'b0}};
          busy_d    = 1'b1;
          state_d   = ST_RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        busy_d    = 1'b1;
        diff_d    = {bit_d_s, diff_q[D_WIDTH-1:1]};
        a_sr_d    = {1'b0, a_sr_q[D_WIDTH-1:1]};
        b_sr_d    = {1'b0, b_sr_q[D_WIDTH-1:1]};
        p_state_d = next_s_s;
        if (count_q == LAST_CNT) begin
          // On the last bit a/b are the operand MSBs and d is the result MSB.
          count_d  = {C_WIDTH{1'b0}};
          borrow_d = next_s_s;
          ovf_d    = (bit_a_s ^ bit_b_s) & (bit_a_s ^ bit_d_s);
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end else begin
          count_d = count_q + C_WIDTH'(1);
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      a_sr_q    <= {D_WIDTH{1'b0}};
      b_sr_q    <= {D_WIDTH{1'b0}};
      diff_q    <= {D_WIDTH{1'b0}};
      count_q   <= {C_WIDTH{1'b0}};
      p_state_q <= 1'b0;
      borrow_q  <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      diff_q    <= diff_d;
      count_q   <= count_d;
      p_state_q <= p_state_d;
      borrow_q  <= borrow_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign ovf_out    = ovf_q;
  assign p_state    = p_state_q;
  assign count_out  = count_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor: computes diff = a_in − b_in one bit per clock, LSB first, using a two-state Mealy borrow machine. It is the inverse-operation companion to the serial adder datapath and shares its operand width, counter width and clock/reset conventions. A start/done handshake frames each operation so that a controller can drive it and a checker can compare results.

## Interface
- D_WIDTH, 8, operand and result width in bits
- C_WIDTH, 4, bit-counter width; must satisfy 2^C_WIDTH ≥ D_WIDTH
- i_clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a_in  in  D_WIDTH  minuend; captured on the accepted-start edge
- b_in  in  D_WIDTH  subtrahend; captured on the accepted-start edge
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; the result is valid
- diff  out  D_WIDTH  difference register
- borrow_out  out  1  final borrow; 1 means a_in < b_in (unsigned)
- ovf_out  out  1  signed overflow of the subtraction
- p_state  out  1  Mealy borrow state (0 = B0 no borrow, 1 = B1 borrow pending)
- count_out  out  C_WIDTH  index of the bit being processed

## Operation
- Control FSM states are IDLE, RUN and DONE. Reset enters IDLE.
- IDLE with start=1:
  - A_sr ← a_in and B_sr ← b_in.
  - diff ← 0, p_state ← B0, count ← 0.
  - Go to RUN.
- RUN, each edge, with a = A_sr[0], b = B_sr[0], s = p_state:
  - d = a ^ b ^ s.
  - next_s = (~a & b) | (~(a ^ b) & s).
  - diff ← {d, diff[D_WIDTH-1:1]}; A_sr and B_sr shift right by one.
  - p_state ← next_s.
  - If count = D_WIDTH−1: go to DONE, count ← 0, borrow_out ← next_s, ovf_out ← (a ^ b) & (a ^ d). On this last bit, a and b are the operand MSBs and d is the result MSB.
  - Otherwise count ← count+1.
- DONE: done=1 for exactly this cycle, then go to IDLE.
- start is ignored in RUN and DONE. No queuing: a start held high through DONE is accepted on the first IDLE edge.
- diff, borrow_out and ovf_out hold their values from DONE until the next accepted start.
- On an accepted start, diff clears; borrow_out and ovf_out keep their old values until the new DONE.
- Reset values: FSM=IDLE, busy=0, done=0, diff=0, borrow_out=0, ovf_out=0, p_state=0, count_out=0, shift registers=0.
- Reset mid-operation aborts at once. No done pulse is produced and the operation is not resumed.
- Reset has priority over start on the same edge.
- count_out reads 0 outside RUN. It never wraps past D_WIDTH−1.

## Timing
- E0 is the edge that samples start=1 in IDLE.
- busy goes high after E0.
- Edges E1..E_D_WIDTH process bits 0..D_WIDTH−1.
- After E_D_WIDTH: done=1, and diff, borrow_out and ovf_out are final.
- After E_(D_WIDTH+1): done=0, busy=0, FSM is IDLE.
- Latency from start edge to done is D_WIDTH cycles. Throughput is one operation per D_WIDTH+2 cycles.
- a_in and b_in may change freely after E0.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then start with a_in=0x08, b_in=0x08 -> done exactly 8 cycles after the start edge; diff=0x00, borrow_out=0, ovf_out=0; p_state=0 during every RUN cycle.
- a_in=0x18, b_in=0x0C -> diff=0x0C, borrow_out=0, ovf_out=0. Then a_in=0x0C, b_in=0x18 -> diff=0xF4, borrow_out=1, ovf_out=0. count_out steps 0..7 in both runs.
- a_in=0x00, b_in=0x01 -> diff=0xFF, borrow_out=1, ovf_out=0. a_in=0x80, b_in=0x01 -> diff=0x7F, borrow_out=0, ovf_out=1.
- Start a_in=0x55, b_in=0x22; pulse start again at count_out=3 with a_in=0xFF, b_in=0x00 -> second start ignored; diff=0x33, single done pulse.
- Assert reset for 1 cycle at count_out=5 of a run -> all outputs zero next cycle, no done pulse. A fresh start with 0x10 − 0x01 -> diff=0x0F.
- Hold start=1 continuously with a_in=0x20, b_in=0x10 -> done pulses every 10 cycles; diff=0x10 at each done; busy low exactly one cycle between operations.
